// File: rtl/ex_mem_if.sv
// EX->MEM boundary bundle: EX-side handshake and payload, MEM-side handshake and head payload.
// The block uses the slave modport; the surrounding pipeline (or a bench) uses master.
interface ex_mem_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [XLEN-1:0]   pc_i;
  logic [XLEN-1:0]   pc_next_i;
  logic [XLEN-1:0]   pc_target_i;
  logic [XLEN-1:0]   alu_result_i;
  logic [XLEN-1:0]   store_data_i;
  logic [REG_AW-1:0] rd_i;
  logic              reg_write_i;
  logic              branch_i;
  logic              zero_i;
  logic              pc_src_i;
  logic [1:0]        mem_con_i;
  logic [1:0]        result_src_i;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   pc_o;
  logic [XLEN-1:0]   pc_next_o;
  logic [XLEN-1:0]   pc_target_o;
  logic [XLEN-1:0]   alu_result_o;
  logic [XLEN-1:0]   store_data_o;
  logic [REG_AW-1:0] rd_o;
  logic              reg_write_o;
  logic              branch_o;
  logic              zero_o;
  logic              pc_src_o;
  logic [1:0]        mem_con_o;
  logic [1:0]        result_src_o;
  logic              taken_o;

  modport slave (
    input  in_valid, flush, out_ready,
    input  pc_i, pc_next_i, pc_target_i, alu_result_i, store_data_i, rd_i,
    input  reg_write_i, branch_i, zero_i, pc_src_i, mem_con_i, result_src_i,
    output in_ready, out_valid,
    output pc_o, pc_next_o, pc_target_o, alu_result_o, store_data_o, rd_o,
    output reg_write_o, branch_o, zero_o, pc_src_o, mem_con_o, result_src_o, taken_o
  );

  modport master (
    output in_valid, flush, out_ready,
    output pc_i, pc_next_i, pc_target_i, alu_result_i, store_data_i, rd_i,
    output reg_write_i, branch_i, zero_i, pc_src_i, mem_con_i, result_src_i,
    input  in_ready, out_valid,
    input  pc_o, pc_next_o, pc_target_o, alu_result_o, store_data_o, rd_o,
    input  reg_write_o, branch_o, zero_o, pc_src_o, mem_con_o, result_src_o, taken_o
  );
endinterface

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with a 2-entry skid buffer and registered in_ready.
// Define EX_MEM_PERF_EN to add the stall_cnt / flush_cnt performance counters.
module ex_mem_skid_reg #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int CTRL_GATE = 1
) (
  input  logic        clk,
  input  logic        rst,
  ex_mem_if.slave     bus
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_next;
    logic [XLEN-1:0]   pc_target;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   store_data;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              branch;
    logic              zero;
    logic              pc_src;
    logic [1:0]        mem_con;
    logic [1:0]        result_src;
    logic              taken;
  } entry_t;

  entry_t in_entry;
  entry_t m_q, s_q, m_d, s_d;
  logic   m_v, s_v, m_v_d, s_v_d;
  logic   in_ready_q;
  logic   accept, drain, gate;

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = m_v & bus.out_ready;

  always_comb begin
    in_entry            = '0;
    in_entry.pc         = bus.pc_i;
    in_entry.pc_next    = bus.pc_next_i;
    in_entry.pc_target  = bus.pc_target_i;
    in_entry.alu_result = bus.alu_result_i;
    in_entry.store_data = bus.store_data_i;
    in_entry.rd         = bus.rd_i;
    in_entry.reg_write  = bus.reg_write_i;
    in_entry.branch     = bus.branch_i;
    in_entry.zero       = bus.zero_i;
    in_entry.pc_src     = bus.pc_src_i;
    in_entry.mem_con    = bus.mem_con_i;
    in_entry.result_src = bus.result_src_i;
    // Redirect decision is resolved here so MEM never recomputes it.
    in_entry.taken      = bus.pc_src_i | (bus.branch_i & bus.zero_i);
  end

  // Next-state: flush wins; otherwise M is always the older entry.
  always_comb begin
    m_d   = m_q;
    s_d   = s_q;
    m_v_d = m_v;
    s_v_d = s_v;
    if (bus.flush) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (drain) begin
      if (s_v) begin
        m_d = s_q;
        if (accept) s_d = in_entry;
        else        s_v_d = 1'b0;
      end else if (accept) begin
        m_d = in_entry;
      end else begin
        m_v_d = 1'b0;
      end
    end else if (m_v) begin
      if (accept) begin
        s_d   = in_entry;
        s_v_d = 1'b1;
      end
    end else if (accept) begin
      m_d   = in_entry;
      m_v_d = 1'b1;
    end
  end

  // Storage stage: M/S registers, valid bits and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q        <= '0;
      s_q        <= '0;
      m_v        <= 1'b0;
      s_v        <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      m_q        <= m_d;
      s_q        <= s_d;
      m_v        <= m_v_d;
      s_v        <= s_v_d;
      in_ready_q <= ~s_v_d;
    end
  end

  assign gate = m_v | (CTRL_GATE == 0);

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = m_v;
  assign bus.pc_o         = m_q.pc;
  assign bus.pc_next_o    = m_q.pc_next;
  assign bus.pc_target_o  = m_q.pc_target;
  assign bus.alu_result_o = m_q.alu_result;
  assign bus.store_data_o = m_q.store_data;
  assign bus.rd_o         = m_q.rd;
  assign bus.reg_write_o  = m_q.reg_write & gate;
  assign bus.branch_o     = m_q.branch;
  assign bus.zero_o       = m_q.zero;
  assign bus.pc_src_o     = m_q.pc_src;
  assign bus.mem_con_o    = m_q.mem_con & {2{gate}};
  assign bus.result_src_o = m_q.result_src;
  assign bus.taken_o      = m_q.taken & m_v;

`ifdef EX_MEM_PERF_EN
  // Counter stage: stalled-head cycles and flushes that killed live entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (m_v & ~bus.out_ready)   stall_cnt <= stall_cnt + 32'd1;
      if (bus.flush & (m_v | s_v)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scoreboard bench for ex_mem_skid_reg: directed vectors push expectations, a monitor pops on each transfer.
// Exercises the EX_MEM_PERF_EN counters only when that macro is defined.
module tb_ex_mem_skid_reg;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_mem_if #(.XLEN(32), .REG_AW(5)) bus ();

`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  ex_mem_skid_reg #(.XLEN(32), .REG_AW(5), .CTRL_GATE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave)
`ifdef EX_MEM_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] tgt;
    logic        taken;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic flush_pending = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every transfer to MEM must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_output", bus.alu_result_o, 64'hdead);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_alu_result", bus.alu_result_o, e.alu);
        chk("sb_pc_target", bus.pc_target_o, e.tgt);
        chk("sb_taken", bus.taken_o, e.taken);
      end
    end
  end

  // One cycle of stimulus; returns at the negedge where the DUT is sampled.
  task automatic step(input logic v, input logic [31:0] alu, input logic [31:0] tgt,
                      input logic br, input logic z, input logic ps, input logic exp_taken,
                      input logic ordy, input logic fl, output logic acc);
    exp_t e;
    @(posedge clk);
    #1;
    if (flush_pending) begin
      q.delete();
      flush_pending = 1'b0;
    end
    bus.in_valid     = v;
    bus.flush        = fl;
    bus.out_ready    = ordy;
    bus.alu_result_i = alu;
    bus.pc_target_i  = tgt;
    bus.pc_i         = 32'h1000 + alu;
    bus.pc_next_i    = 32'h1004 + alu;
    bus.store_data_i = ~alu;
    bus.rd_i         = alu[4:0];
    bus.branch_i     = br;
    bus.zero_i       = z;
    bus.pc_src_i     = ps;
    bus.reg_write_i  = v;
    bus.mem_con_i    = v ? 2'b10 : 2'b00;
    bus.result_src_i = 2'b01;
    @(negedge clk);
    acc = v & bus.in_ready & ~fl;
    if (acc) begin
      e.alu   = alu;
      e.tgt   = tgt;
      e.taken = exp_taken;
      q.push_back(e);
    end
    if (fl) flush_pending = 1'b1;
  endtask

  task automatic idle(input logic ordy);
    logic a;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, ordy, 1'b0, a);
  endtask

  task automatic send(input logic [31:0] alu, input logic ordy, output logic acc);
    step(1'b1, alu, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, ordy, 1'b0, acc);
  endtask

  initial begin
    logic acc;
    int   guard;
`ifdef EX_MEM_PERF_EN
    logic [31:0] s0;
    logic [15:0] f0;
`endif

    // Reset with random inputs toggling.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid     = 1'($urandom);
      bus.flush        = 1'($urandom);
      bus.out_ready    = 1'($urandom);
      bus.alu_result_i = $urandom;
      bus.pc_i         = $urandom;
      bus.pc_next_i    = $urandom;
      bus.pc_target_i  = $urandom;
      bus.store_data_i = $urandom;
      bus.rd_i         = 5'($urandom);
      bus.reg_write_i  = 1'($urandom);
      bus.branch_i     = 1'($urandom);
      bus.zero_i       = 1'($urandom);
      bus.pc_src_i     = 1'($urandom);
      bus.mem_con_i    = 2'($urandom);
      bus.result_src_i = 2'($urandom);
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
    end
    chk("rst_alu_result", bus.alu_result_o, 32'h0);
    chk("rst_pc", bus.pc_o, 32'h0);
    chk("rst_pc_target", bus.pc_target_o, 32'h0);
    chk("rst_rd", bus.rd_o, 5'h0);
    chk("rst_reg_write", bus.reg_write_o, 1'b0);
    chk("rst_mem_con", bus.mem_con_o, 2'b00);
    chk("rst_taken", bus.taken_o, 1'b0);
    chk("rst_misc", |{bus.pc_next_o, bus.store_data_o, bus.branch_o, bus.zero_o,
                      bus.pc_src_o, bus.result_src_o}, 1'b0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1'b1);
    idle(1'b1);
    chk("post_rst_out_valid", bus.out_valid, 1'b0);

    // Streaming with out_ready high: 1-cycle latency, ready stays 1.
    send(32'h10, 1'b1, acc);
    chk("stream_acc0", acc, 1'b1);
    send(32'h20, 1'b1, acc);
    chk("stream_head0", bus.alu_result_o, 32'h10);
    chk("stream_ready1", bus.in_ready, 1'b1);
    send(32'h30, 1'b1, acc);
    chk("stream_head1", bus.alu_result_o, 32'h20);
    chk("stream_ready2", bus.in_ready, 1'b1);
    idle(1'b1);
    chk("stream_head2", bus.alu_result_o, 32'h30);
    idle(1'b1);
    chk("stream_empty", bus.out_valid, 1'b0);

    // Backpressure: A in M, B in skid, C held by source.
    send(32'h11, 1'b0, acc);
    send(32'h22, 1'b0, acc);
    chk("bp_b_acc", acc, 1'b1);
    chk("bp_head_a", bus.alu_result_o, 32'h11);
    send(32'h33, 1'b0, acc);
    chk("bp_ready_low", bus.in_ready, 1'b0);
    chk("bp_c_held", acc, 1'b0);
    chk("bp_head_still_a", bus.alu_result_o, 32'h11);
    send(32'h33, 1'b0, acc);
    chk("bp_c_held2", acc, 1'b0);
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 10) begin
      send(32'h33, 1'b1, acc);
      guard++;
    end
    chk("bp_c_accepted", acc, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("bp_drained", bus.out_valid, 1'b0);

    // Flush with M and S full and D offered: everything dies.
    send(32'h55, 1'b0, acc);
    send(32'h66, 1'b0, acc);
    chk("fl_skid_acc", acc, 1'b1);
    step(1'b1, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    idle(1'b0);
    chk("fl_out_valid", bus.out_valid, 1'b0);
    chk("fl_in_ready", bus.in_ready, 1'b1);
    chk("fl_reg_write_gated", bus.reg_write_o, 1'b0);
    chk("fl_mem_con_gated", bus.mem_con_o, 2'b00);
    // Flush while empty and ready: the offered entry is discarded too.
    step(1'b1, 32'h45, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    idle(1'b1);
    chk("fl2_out_valid", bus.out_valid, 1'b0);
    idle(1'b1);
    chk("fl2_still_empty", bus.out_valid, 1'b0);

    // Branch decisions travel with their entries.
    step(1'b1, 32'h77, 32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    step(1'b1, 32'h78, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    chk("br_taken_head", bus.taken_o, 1'b1);
    chk("br_target_head", bus.pc_target_o, 32'h100);
    step(1'b1, 32'h79, 32'h300, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    chk("br_not_taken", bus.taken_o, 1'b0);
    chk("br_target2", bus.pc_target_o, 32'h200);
    idle(1'b1);
    chk("br_pc_src_taken", bus.taken_o, 1'b1);
    idle(1'b1);
    chk("br_taken_gated", bus.taken_o, 1'b0);

`ifdef EX_MEM_PERF_EN
    // Hold the head 5 cycles, then flush once while draining.
    send(32'h88, 1'b0, acc);
    idle(1'b0);
    s0 = stall_cnt;
    f0 = flush_cnt;
    for (int i = 0; i < 4; i++) idle(1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    idle(1'b1);
    chk("perf_stall_cnt", stall_cnt - s0, 32'd5);
    chk("perf_flush_cnt", flush_cnt - f0, 16'd1);
`endif

    idle(1'b1);
    idle(1'b1);
    chk("sb_queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end
endmodule
